// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : des_pkg
//  Description : Shared DES key-schedule constants and types. PC-1/PC-2 are
//                stored as 0-based bit indices into FIPS-ordered vectors
//                (index 0 = MSB). Rotate schedules are indexed by round_idx.
//                Optional macro DES_KS_DIR_SEL_EN (encrypt-order support)
//                uses ENC_ROT.
//  Revision    : 1.0 - initial release
// ============================================================================
package des_pkg;

    typedef logic [0:63] des_key_t;
    typedef logic [0:27] des_half_t;
    typedef logic [0:47] des_subkey_t;

    // PC-1: source bit of key_in for each of the 56 C||D bits.
    localparam logic [5:0] PC1 [56] = '{
        6'd56, 6'd48, 6'd40, 6'd32, 6'd24, 6'd16, 6'd8,
        6'd0,  6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17,
        6'd9,  6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26,
        6'd18, 6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35,
        6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22, 6'd14,
        6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29, 6'd21,
        6'd13, 6'd5,  6'd60, 6'd52, 6'd44, 6'd36, 6'd28,
        6'd20, 6'd12, 6'd4,  6'd27, 6'd19, 6'd11, 6'd3
    };

    // PC-2: source bit of C||D for each of the 48 subkey bits.
    localparam logic [5:0] PC2 [48] = '{
        6'd13, 6'd16, 6'd10, 6'd23, 6'd0,  6'd4,
        6'd2,  6'd27, 6'd14, 6'd5,  6'd20, 6'd9,
        6'd22, 6'd18, 6'd11, 6'd3,  6'd25, 6'd7,
        6'd15, 6'd6,  6'd26, 6'd19, 6'd12, 6'd1,
        6'd40, 6'd51, 6'd30, 6'd36, 6'd46, 6'd54,
        6'd29, 6'd39, 6'd50, 6'd44, 6'd32, 6'd47,
        6'd43, 6'd48, 6'd38, 6'd55, 6'd33, 6'd52,
        6'd45, 6'd41, 6'd49, 6'd35, 6'd28, 6'd31
    };

    // Right-rotate applied when leaving round_idx i (decrypt order).
    // Entry 0 is never used: leaving round 0 ends the run.
    localparam logic [1:0] DEC_ROT [16] = '{
        2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Left-rotate that produces round (i+1), i.e. indexed by round_idx.
    localparam logic [1:0] ENC_ROT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // Rotations toward bit 0 (left) / away from bit 0 (right); n is 1 or 2.
    function automatic des_half_t rot_left(input des_half_t h, input logic [1:0] n);
        return (n == 2'd1) ? {h[1:27], h[0]} : {h[2:27], h[0:1]};
    endfunction

    function automatic des_half_t rot_right(input des_half_t h, input logic [1:0] n);
        return (n == 2'd1) ? {h[27], h[0:26]} : {h[26:27], h[0:25]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_key_sched_dec_if.sv
`default_nettype none
// ============================================================================
//  Module      : des_key_sched_dec_if
//  Description : Key-load and subkey-stream handshake bundle.
//                master = key producer / subkey consumer, slave = scheduler.
//                Signals: key_in, key_valid, key_ready, subkey_out,
//                subkey_valid, subkey_ready, round_idx, last
//                (+ dir when DES_KS_DIR_SEL_EN is defined).
//  Revision    : 1.0 - initial release
// ============================================================================
interface des_key_sched_dec_if;
    import des_pkg::*;

    des_key_t    key_in;
    logic        key_valid;
    logic        key_ready;
    des_subkey_t subkey_out;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round_idx;
    logic        last;
`ifdef DES_KS_DIR_SEL_EN
    logic        dir;

    modport master (output key_in, key_valid, subkey_ready, dir,
                    input  key_ready, subkey_out, subkey_valid, round_idx, last);
    modport slave  (input  key_in, key_valid, subkey_ready, dir,
                    output key_ready, subkey_out, subkey_valid, round_idx, last);
`else
    modport master (output key_in, key_valid, subkey_ready,
                    input  key_ready, subkey_out, subkey_valid, round_idx, last);
    modport slave  (input  key_in, key_valid, subkey_ready,
                    output key_ready, subkey_out, subkey_valid, round_idx, last);
`endif
endinterface
`default_nettype wire

// File: rtl/des_pc2.sv
`default_nettype none
// ============================================================================
//  Module      : des_pc2
//  Description : Combinational DES Permuted Choice 2.
//                Ports: c, d (28-bit halves) -> subkey (48-bit), FIPS order.
//  Revision    : 1.0 - initial release
// ============================================================================
module des_pc2
    import des_pkg::*;
(
    input  des_half_t   c,
    input  des_half_t   d,
    output des_subkey_t subkey
);
    logic [0:55] cd;

    always_comb begin
        cd     = {c, d};
        subkey = '0;
        for (int i = 0; i < 48; i++) begin
            subkey[i] = cd[PC2[i]];
        end
    end
endmodule
`default_nettype wire

// File: rtl/des_key_sched_dec.sv
`default_nettype none
// ============================================================================
//  Module      : des_key_sched_dec
//  Description : Iterative DES key schedule emitting K16..K1 (decrypt order),
//                one subkey per valid/ready handshake.
//                Ports: clk, rst_n (async active-low), bus (slave modport of
//                des_key_sched_dec_if).
//                Macro DES_KS_DIR_SEL_EN adds bus.dir: 1 selects K1..K16.
//  Revision    : 1.0 - initial release
// ============================================================================
module des_key_sched_dec
    import des_pkg::*;
#(
    parameter int NUM_ROUNDS = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    des_key_sched_dec_if.slave bus
);
    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EMIT = 1'b1} state_t;

    state_t      state_q, state_d;
    des_half_t   c_q, c_d, d_q, d_d;
    logic [3:0]  round_idx_q, round_idx_d;
    logic        key_ready_q, key_ready_d;
    logic        subkey_valid_q, subkey_valid_d;
    logic        last_q, last_d;
    logic        dir_q, dir_d;
    logic [0:55] pc1_cd;
    logic [3:0]  final_idx;

    always_comb begin
        pc1_cd = '0;
        for (int i = 0; i < 56; i++) begin
            pc1_cd[i] = bus.key_in[PC1[i]];
        end
    end

    // Encrypt order counts up and ends at 15; decrypt counts down to 0.
    assign final_idx = dir_q ? 4'd15 : 4'd0;

    always_comb begin
        state_d        = state_q;
        c_d            = c_q;
        d_d            = d_q;
        round_idx_d    = round_idx_q;
        key_ready_d    = key_ready_q;
        subkey_valid_d = subkey_valid_q;
        last_d         = last_q;
        dir_d          = dir_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.key_valid) begin
                    // C16/D16 == C0/D0 (total shift 28), so K16 needs no rotate.
                    c_d            = pc1_cd[0:27];
                    d_d            = pc1_cd[28:55];
                    round_idx_d    = 4'd15;
                    dir_d          = 1'b0;
                    state_d        = ST_EMIT;
                    key_ready_d    = 1'b0;
                    subkey_valid_d = 1'b1;
                    last_d         = 1'b0;
`ifdef DES_KS_DIR_SEL_EN
                    dir_d = bus.dir;
                    if (bus.dir) begin
                        c_d         = rot_left(pc1_cd[0:27], ENC_ROT[0]);
                        d_d         = rot_left(pc1_cd[28:55], ENC_ROT[0]);
                        round_idx_d = 4'd0;
                    end
`endif
                end
            end
            ST_EMIT: begin
                if (bus.subkey_ready) begin
                    if (round_idx_q == final_idx) begin
                        state_d        = ST_IDLE;
                        c_d            = '0;
                        d_d            = '0;
                        round_idx_d    = 4'd15;
                        key_ready_d    = 1'b1;
                        subkey_valid_d = 1'b0;
                        last_d         = 1'b0;
                    end else if (dir_q) begin
                        c_d         = rot_left(c_q, ENC_ROT[round_idx_q + 4'd1]);
                        d_d         = rot_left(d_q, ENC_ROT[round_idx_q + 4'd1]);
                        round_idx_d = round_idx_q + 4'd1;
                        last_d      = (round_idx_q == 4'd14);
                    end else begin
                        c_d         = rot_right(c_q, DEC_ROT[round_idx_q]);
                        d_d         = rot_right(d_q, DEC_ROT[round_idx_q]);
                        round_idx_d = round_idx_q - 4'd1;
                        last_d      = (round_idx_q == 4'd1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            c_q            <= '0;
            d_q            <= '0;
            round_idx_q    <= 4'd15;
            key_ready_q    <= 1'b1;
            subkey_valid_q <= 1'b0;
            last_q         <= 1'b0;
            dir_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            c_q            <= c_d;
            d_q            <= d_d;
            round_idx_q    <= round_idx_d;
            key_ready_q    <= key_ready_d;
            subkey_valid_q <= subkey_valid_d;
            last_q         <= last_d;
            dir_q          <= dir_d;
        end
    end

    des_pc2 u_pc2 (
        .c      (c_q),
        .d      (d_q),
        .subkey (bus.subkey_out)
    );

    assign bus.key_ready    = key_ready_q;
    assign bus.subkey_valid = subkey_valid_q;
    assign bus.round_idx    = round_idx_q;
    assign bus.last         = last_q;

    a_round_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        subkey_valid_q |-> (int'(round_idx_q) < NUM_ROUNDS));

endmodule
`default_nettype wire
